// File: rtl/arb_pkg.sv
// Shared definitions for the shared-register arbiter: FSM encodings, default sizes, clog2.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_LOCK = 4;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shared_reg.sv
// Shared storage register: loads d when en is high, otherwise holds.
// Latency: q reflects d one clock after en.
// Backpressure: none; always accepts a load.
// Ports: CLK, RESET (async, active-high, clears to 0), en, d[WIDTH], q[WIDTH].
module shared_reg #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N writers, with bounded lock.
// Latency: req at edge k -> gnt in cycle k+1 -> write + ack/Q in cycle k+2; one write/cycle sustained.
// Backpressure: requesters hold req until their one-cycle ack; no ack means keep holding.
// Ports: CLK, RESET (async, active-high), req[N], lock[N], wdata[N*WIDTH] (slot i at i*WIDTH),
//        gnt[N] one-hot, ack[N] pulse, Q[WIDTH], owner, busy (in GRANT), valid (Q written since reset).
module shared_reg_arbiter
    import arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          lock,
    input  logic [N*WIDTH-1:0]    wdata,
    output logic [N-1:0]          gnt,
    output logic [N-1:0]          ack,
    output logic [WIDTH-1:0]      Q,
    output logic [clog2(N)-1:0]   owner,
    output logic                  busy,
    output logic                  valid
);

    localparam int OW  = clog2(N);
    localparam int LCW = clog2(MAX_LOCK) + 1;

    state_t             state;
    logic [LCW-1:0]     lock_cnt;
    logic [WIDTH-1:0]   wd_arr [N];
    logic               wr_en;
    logic [WIDTH-1:0]   wr_dat;
    logic               keep;
    logic [N-1:0]       pick_src;
    logic [OW-1:0]      pick;

    function automatic logic [N-1:0] onehot(input logic [OW-1:0] i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // First set bit scanning ptr+1, ptr+2, ... wrapping; ptr itself is checked last.
    function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] r, input logic [OW-1:0] ptr);
        logic [OW-1:0] w;
        logic [OW-1:0] idx;
        logic          found;
        w     = ptr;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = OW'((int'(ptr) + i) % N);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_wd
        assign wd_arr[i] = wdata[i*WIDTH +: WIDTH];
    end

    always_comb begin
        wr_en    = (state == ST_GRANT) && req[owner];
        wr_dat   = wd_arr[owner];
        keep     = lock[owner] && req[owner] && (int'(lock_cnt) < MAX_LOCK - 1);
        // The owner committing on this edge must not win again off the same req level.
        pick_src = (state == ST_IDLE) ? req : (req & ~(wr_en ? onehot(owner) : '0));
        pick     = rr_pick(pick_src, owner);
    end

    assign busy = (state == ST_GRANT);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            ack      <= '0;
            owner    <= OW'(N - 1);
            valid    <= 1'b0;
            lock_cnt <= '0;
        end else begin
            ack <= wr_en ? onehot(owner) : '0;
            if (wr_en) begin
                valid <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    lock_cnt <= '0;
                    if (|pick_src) begin
                        state <= ST_GRANT;
                        gnt   <= onehot(pick);
                        owner <= pick;
                    end else begin
                        gnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (keep) begin
                        lock_cnt <= lock_cnt + LCW'(1);
                    end else begin
                        lock_cnt <= '0;
                        if (|pick_src) begin
                            gnt   <= onehot(pick);
                            owner <= pick;
                        end else begin
                            state <= ST_IDLE;
                            gnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    shared_reg #(.WIDTH(WIDTH)) u_shared_reg (
        .CLK   (CLK),
        .RESET (RESET),
        .en    (wr_en),
        .d     (wr_dat),
        .q     (Q)
    );

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter (N=4, WIDTH=8, MAX_LOCK=4).
// Directed vector table, a mid-grant reset sequence, then random traffic vs. a reference model.
module tb_shared_reg_arbiter;

    localparam int NQ = 4;
    localparam int WQ = 8;
    localparam int ML = 4;

    logic        CLK;
    logic        RESET;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  Q;
    logic [1:0]  owner;
    logic        busy;
    logic        valid;

    int checks = 0;
    int errors = 0;

    shared_reg_arbiter #(.N(NQ), .WIDTH(WQ), .MAX_LOCK(ML)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .req   (req),
        .lock  (lock),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .Q     (Q),
        .owner (owner),
        .busy  (busy),
        .valid (valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eg, input logic [3:0] ea,
                           input logic [7:0] eq, input logic [1:0] eo, input logic eb, input logic ev);
        chk({tag, "_gnt"},   32'(gnt),   32'(eg));
        chk({tag, "_ack"},   32'(ack),   32'(ea));
        chk({tag, "_Q"},     32'(Q),     32'(eq));
        chk({tag, "_owner"}, 32'(owner), 32'(eo));
        chk({tag, "_busy"},  32'(busy),  32'(eb));
        chk({tag, "_valid"}, 32'(valid), 32'(ev));
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  rq;
        logic [3:0]  lk;
        logic [31:0] wd;
        logic [3:0]  g;
        logic [3:0]  a;
        logic [7:0]  q;
        logic [1:0]  o;
        logic        b;
        logic        v;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic [3:0] lk,
                                input logic [31:0] wd, input logic [3:0] g, input logic [3:0] a,
                                input logic [7:0] q, input logic [1:0] o, input logic b, input logic v);
        vec_t t;
        t.rst = rst; t.rq = rq; t.lk = lk; t.wd = wd;
        t.g = g; t.a = a; t.q = q; t.o = o; t.b = b; t.v = v;
        return t;
    endfunction

    vec_t tbl [19];

    // Reference model: the register file as the spec describes it, tracked at transaction level.
    bit        m_busy;
    int        m_own;
    int        m_run;
    logic [7:0] m_q;
    bit        m_valid;
    logic [3:0] m_ack;

    // Candidates in priority order after 'from' (from itself last); first requesting one wins.
    function automatic int ref_pick(input logic [3:0] r, input int from);
        int order[$];
        for (int k = 1; k <= NQ; k++) order.push_back((from + k) % NQ);
        foreach (order[j]) begin
            if (((r >> order[j]) & 4'd1) != 4'd0) return order[j];
        end
        return -1;
    endfunction

    task automatic model_edge();
        bit         wrote;
        logic [3:0] cand;
        int         w;
        m_ack = 4'd0;
        if (!m_busy) begin
            w = ref_pick(req, m_own);
            if (w >= 0) begin
                m_busy = 1; m_own = w; m_run = 0;
            end
        end else begin
            wrote = ((req >> m_own) & 4'd1) != 4'd0;
            if (wrote) begin
                m_q     = 8'((wdata >> (8 * m_own)) & 32'hFF);
                m_valid = 1;
                m_ack   = 4'(1 << m_own);
            end
            if (wrote && (((lock >> m_own) & 4'd1) != 4'd0) && (m_run + 1 < ML)) begin
                m_run++;
            end else begin
                cand  = wrote ? (req & ~4'(1 << m_own)) : req;
                m_run = 0;
                w     = ref_pick(cand, m_own);
                if (w >= 0) m_own = w;
                else        m_busy = 0;
            end
        end
    endtask

    initial begin
        RESET = 1'b1; req = '0; lock = '0; wdata = '0;

        // Single request, then fairness sweep, lock bound, withdrawal.
        tbl[0]  = mk(0, 4'b0001, 4'b0000, 32'h0000_00A5, 4'b0001, 4'b0000, 8'h00, 2'd0, 1, 0);
        tbl[1]  = mk(0, 4'b0001, 4'b0000, 32'h0000_00A5, 4'b0000, 4'b0001, 8'hA5, 2'd0, 0, 1);
        tbl[2]  = mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 8'hA5, 2'd0, 0, 1);
        tbl[3]  = mk(1, 4'b1111, 4'b0000, 32'h4433_2211, 4'b0001, 4'b0000, 8'h00, 2'd0, 1, 0);
        tbl[4]  = mk(0, 4'b1111, 4'b0000, 32'h4433_2211, 4'b0010, 4'b0001, 8'h11, 2'd1, 1, 1);
        tbl[5]  = mk(0, 4'b1110, 4'b0000, 32'h4433_2211, 4'b0100, 4'b0010, 8'h22, 2'd2, 1, 1);
        tbl[6]  = mk(0, 4'b1100, 4'b0000, 32'h4433_2211, 4'b1000, 4'b0100, 8'h33, 2'd3, 1, 1);
        tbl[7]  = mk(0, 4'b1000, 4'b0000, 32'h4433_2211, 4'b0000, 4'b1000, 8'h44, 2'd3, 0, 1);
        tbl[8]  = mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 8'h44, 2'd3, 0, 1);
        tbl[9]  = mk(0, 4'b0100, 4'b0100, 32'h00C0_0000, 4'b0100, 4'b0000, 8'h44, 2'd2, 1, 1);
        tbl[10] = mk(0, 4'b0110, 4'b0100, 32'h00C1_0000, 4'b0100, 4'b0100, 8'hC1, 2'd2, 1, 1);
        tbl[11] = mk(0, 4'b0110, 4'b0100, 32'h00C2_0000, 4'b0100, 4'b0100, 8'hC2, 2'd2, 1, 1);
        tbl[12] = mk(0, 4'b0110, 4'b0100, 32'h00C3_0000, 4'b0100, 4'b0100, 8'hC3, 2'd2, 1, 1);
        tbl[13] = mk(0, 4'b0110, 4'b0100, 32'h00C4_0000, 4'b0010, 4'b0100, 8'hC4, 2'd1, 1, 1);
        tbl[14] = mk(0, 4'b0010, 4'b0000, 32'h0000_7700, 4'b0000, 4'b0010, 8'h77, 2'd1, 0, 1);
        tbl[15] = mk(0, 4'b0001, 4'b0000, 32'h0000_005A, 4'b0001, 4'b0000, 8'h77, 2'd0, 1, 1);
        tbl[16] = mk(0, 4'b1000, 4'b0000, 32'h9900_0000, 4'b1000, 4'b0000, 8'h77, 2'd3, 1, 1);
        tbl[17] = mk(0, 4'b1000, 4'b0000, 32'h9900_0000, 4'b0000, 4'b1000, 8'h99, 2'd3, 0, 1);
        tbl[18] = mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 8'h99, 2'd3, 0, 1);

        #3;
        chk_all("reset", 4'b0000, 4'b0000, 8'h00, 2'd3, 0, 0);
        @(negedge CLK);
        RESET = 1'b0;

        foreach (tbl[i]) begin
            if (tbl[i].rst) begin
                RESET = 1'b1; #1; RESET = 1'b0;
            end
            req = tbl[i].rq; lock = tbl[i].lk; wdata = tbl[i].wd;
            @(posedge CLK);
            @(negedge CLK);
            chk_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].a, tbl[i].q, tbl[i].o, tbl[i].b, tbl[i].v);
        end

        // Reset while requester 1 holds the grant: write is lost, arbitration restarts at 0.
        RESET = 1'b1; #1; RESET = 1'b0;
        req = 4'b0010; lock = '0; wdata = 32'h0000_3C00;
        @(posedge CLK);
        @(negedge CLK);
        chk("midrst_pre_gnt", 32'(gnt), 32'h2);
        RESET = 1'b1;
        #1;
        chk_all("midrst_async", 4'b0000, 4'b0000, 8'h00, 2'd3, 0, 0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        req = 4'b0011; wdata = 32'h0000_3C5A;
        @(posedge CLK);
        @(negedge CLK);
        chk_all("midrst_rel", 4'b0001, 4'b0000, 8'h00, 2'd0, 1, 0);
        @(posedge CLK);
        @(negedge CLK);
        chk_all("midrst_wr0", 4'b0010, 4'b0001, 8'h5A, 2'd1, 1, 1);
        req = 4'b0000;

        // Random traffic against the reference model.
        @(negedge CLK);
        RESET = 1'b1; #1; RESET = 1'b0;
        req = '0; lock = '0; wdata = '0;
        m_busy = 0; m_own = NQ - 1; m_run = 0; m_q = 8'h00; m_valid = 0; m_ack = 4'd0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NQ; i++) begin
                if (req[i]) begin
                    if (m_ack[i] && !(lock[i] && $urandom_range(0, 3) != 0)) req[i] = 1'b0;
                    else if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                end
                lock[i] = ($urandom_range(0, 2) == 0);
            end
            wdata = $urandom;
            @(posedge CLK);
            model_edge();
            @(negedge CLK);
            chk_all($sformatf("rnd%0d", c), m_busy ? 4'(1 << m_own) : 4'd0, m_ack, m_q,
                    2'(m_own), m_busy, m_valid);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
